// File: rtl/dma_priority_arbiter_pkg.sv
// Shared definitions for the DMA priority arbiter.
// Holds the channel count, the bit positions of the command register
// fields, the arbiter state encoding and a one-hot helper.
package dma_priority_arbiter_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // Bit positions inside commandReg
  localparam int CMD_DISABLE    = 2;
  localparam int CMD_ROTATE     = 4;
  localparam int CMD_DREQ_SENSE = 6;
  localparam int CMD_DACK_SENSE = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Handshake bundle between the arbiter and its environment.
//   slave  : arbiter side (requests/command in, HRQ/DACK/grant out)
//   master : environment side (register file, CPU hold logic, timing control)
interface dma_priority_arbiter_if;
  import dma_priority_arbiter_pkg::*;

  logic [NUM_CH-1:0] DREQ;
  logic [7:0]        commandReg;
  logic [NUM_CH-1:0] maskReg;
  logic [NUM_CH-1:0] requestReg;
  logic              HLDA;
  logic              serviceDone;
  logic              eopDone;

  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [NUM_CH-1:0] VALID_DREQ;
  logic [CH_W-1:0]   activeCh;
  logic [NUM_CH-1:0] swReqClr;

  modport slave (
    input  DREQ, commandReg, maskReg, requestReg, HLDA, serviceDone, eopDone,
    output HRQ, DACK, VALID_DREQ, activeCh, swReqClr
  );

  modport master (
    output DREQ, commandReg, maskReg, requestReg, HLDA, serviceDone, eopDone,
    input  HRQ, DACK, VALID_DREQ, activeCh, swReqClr
  );
endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational rotating priority encoder.
//   req    : effective channel requests
//   rotPtr : highest-priority channel when rotating
//   rotate : 1 = rotating priority, 0 = fixed (channel 0 highest)
//   winner : selected channel (only meaningful when req != 0)
module dma_priority_encoder
  import dma_priority_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rotPtr,
  input  logic              rotate,
  output logic [CH_W-1:0]   winner
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit
  // is the last assignment and wins.
  always_comb begin
    base   = rotate ? rotPtr : '0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = base + CH_W'(k);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter.
// Qualifies hardware/software requests, picks a channel with fixed or
// rotating priority, runs the HRQ/HLDA hold handshake and drives the
// channel acknowledge until timing control reports completion.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : dma_priority_arbiter_if.slave (requests, command/mask,
//                HLDA, serviceDone/eopDone in; HRQ, DACK, VALID_DREQ,
//                activeCh, swReqClr out)
module dma_priority_arbiter
  import dma_priority_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4  // only 4 channels are supported
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_priority_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic [CH_W-1:0]   active_q;
  logic [CH_W-1:0]   rot_q;
  logic              hrq_q;
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] swclr_q;

  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   winner;
  logic              rotate;

  // Hardware requests are polarity-corrected and masked; software
  // requests bypass the mask.
  always_comb begin
    eff_req = ((bus.DREQ ^ {NUM_CH{bus.commandReg[CMD_DREQ_SENSE]}}) & ~bus.maskReg)
              | bus.requestReg;
    rotate  = bus.commandReg[CMD_ROTATE];
  end

  dma_priority_encoder u_enc (
    .req    (eff_req),
    .rotPtr (rot_q),
    .rotate (rotate),
    .winner (winner)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      rot_q    <= '0;
      hrq_q    <= 1'b0;
      valid_q  <= '0;
      swclr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.commandReg[CMD_DISABLE] && (eff_req != '0)) begin
            state_q  <= ST_REQ;
            active_q <= winner;
            hrq_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.HLDA) begin
            state_q <= ST_GRANT;
            valid_q <= ch_onehot(active_q);
          end else if (!eff_req[active_q]) begin
            // Request withdrawn before the bus was granted
            state_q <= ST_IDLE;
            hrq_q   <= 1'b0;
          end
        end
        ST_GRANT: begin
          // serviceDone has precedence over a simultaneous HLDA fall
          if (bus.serviceDone) begin
            state_q <= ST_DONE;
            hrq_q   <= 1'b0;
            valid_q <= '0;
            // eopDone is only valid alongside serviceDone, so the clear
            // pulse is decided here and shown during DONE.
            if (bus.requestReg[active_q] || bus.eopDone)
              swclr_q <= ch_onehot(active_q);
          end else if (!bus.HLDA) begin
            state_q <= ST_IDLE;
            hrq_q   <= 1'b0;
            valid_q <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          swclr_q <= '0;
          if (rotate) rot_q <= active_q + CH_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          hrq_q   <= 1'b0;
          valid_q <= '0;
          swclr_q <= '0;
        end
      endcase
      // Leaving rotating mode restarts the rotation from channel 0
      if (!rotate) rot_q <= '0;
    end
  end

  // valid_q is cleared by reset, so DACK sits at its inactive level for
  // whatever polarity commandReg currently selects.
  assign bus.DACK       = bus.commandReg[CMD_DACK_SENSE] ? valid_q : ~valid_q;
  assign bus.VALID_DREQ = valid_q;
  assign bus.HRQ        = hrq_q;
  assign bus.activeCh   = active_q;
  assign bus.swReqClr   = swclr_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dma_priority_arbiter_if bus();

  dma_priority_arbiter dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [3:0] req;
    logic       eop;
    logic [1:0] ch;
    logic [3:0] dack;
    logic [3:0] swclr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] idle_dreq(input logic [7:0] cmd);
    return cmd[6] ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] ch);
    logic [3:0] one;
    one = 4'b0001;
    return one << ch;
  endfunction

  // Full request -> grant -> done cycle for one table entry
  task automatic run_vec(input int i, input vec_t v);
    string n;
    n = $sformatf("v%0d", i);
    bus.commandReg = v.cmd; bus.DREQ = v.dreq; bus.maskReg = v.mask;
    bus.requestReg = v.req; bus.HLDA = 1'b0; bus.serviceDone = 1'b0; bus.eopDone = 1'b0;
    tick;
    chk({n, " hrq"},   {7'd0, bus.HRQ}, 8'd1);
    chk({n, " ch"},    {6'd0, bus.activeCh}, {6'd0, v.ch});
    tick;
    chk({n, " nogrant"}, {4'd0, bus.VALID_DREQ}, 8'd0);
    bus.HLDA = 1'b1;
    tick;
    chk({n, " valid"}, {4'd0, bus.VALID_DREQ}, {4'd0, oh(v.ch)});
    chk({n, " dack"},  {4'd0, bus.DACK}, {4'd0, v.dack});
    // Request/mask churn while granted must not move the grant
    bus.DREQ = ~v.dreq; bus.maskReg = ~v.mask;
    tick;
    chk({n, " lock"},  {6'd0, bus.activeCh}, {6'd0, v.ch});
    bus.serviceDone = 1'b1; bus.eopDone = v.eop;
    tick;
    bus.serviceDone = 1'b0; bus.eopDone = 1'b0;
    chk({n, " done hrq"}, {7'd0, bus.HRQ}, 8'd0);
    chk({n, " swclr"}, {4'd0, bus.swReqClr}, {4'd0, v.swclr});
    bus.DREQ = idle_dreq(v.cmd); bus.maskReg = 4'h0; bus.requestReg = 4'h0; bus.HLDA = 1'b0;
    tick;
    chk({n, " swclr off"}, {4'd0, bus.swReqClr}, 8'd0);
  endtask

  // Bring a request up to GRANT
  task automatic to_grant(input logic [7:0] cmd, input logic [3:0] dreq, input logic [3:0] req);
    bus.commandReg = cmd; bus.DREQ = dreq; bus.maskReg = 4'h0; bus.requestReg = req;
    bus.HLDA = 1'b0; bus.serviceDone = 1'b0; bus.eopDone = 1'b0;
    tick;
    bus.HLDA = 1'b1;
    tick;
  endtask

  initial begin
    //         cmd    dreq     mask     req      eop  ch     dack     swclr
    vecs[0]  = '{8'h00, 4'b1010, 4'h0, 4'b0000, 1'b0, 2'd1, 4'b1101, 4'b0000}; // fixed
    vecs[1]  = '{8'h10, 4'b0010, 4'h0, 4'b0000, 1'b0, 2'd1, 4'b1101, 4'b0000}; // rot -> ptr 2
    vecs[2]  = '{8'h10, 4'b1111, 4'h0, 4'b0000, 1'b0, 2'd2, 4'b1011, 4'b0000}; // ptr 3
    vecs[3]  = '{8'h10, 4'b1111, 4'h0, 4'b0000, 1'b0, 2'd3, 4'b0111, 4'b0000}; // ptr 0
    vecs[4]  = '{8'h10, 4'b1111, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b1110, 4'b0000}; // ptr 1
    vecs[5]  = '{8'h00, 4'b1111, 4'hF, 4'b0100, 1'b0, 2'd2, 4'b1011, 4'b0100}; // sw req, ptr reset
    vecs[6]  = '{8'h10, 4'b0001, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b1110, 4'b0000}; // ptr 1
    vecs[7]  = '{8'h00, 4'b1111, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b1110, 4'b0000}; // fixed, ptr reset
    vecs[8]  = '{8'h10, 4'b1111, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b1110, 4'b0000}; // ptr was reset
    vecs[9]  = '{8'hC0, 4'b1110, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000}; // polarity
    vecs[10] = '{8'h00, 4'b0100, 4'h0, 4'b0000, 1'b1, 2'd2, 4'b1011, 4'b0100}; // eop clear

    bus.commandReg = 8'h00; bus.DREQ = 4'h0; bus.maskReg = 4'h0; bus.requestReg = 4'h0;
    bus.HLDA = 1'b0; bus.serviceDone = 1'b0; bus.eopDone = 1'b0;
    #2;
    chk("rst hrq",   {7'd0, bus.HRQ}, 8'd0);
    chk("rst valid", {4'd0, bus.VALID_DREQ}, 8'd0);
    chk("rst swclr", {4'd0, bus.swReqClr}, 8'd0);
    chk("rst ch",    {6'd0, bus.activeCh}, 8'd0);
    chk("rst dack lo", {4'd0, bus.DACK}, 8'h0F);
    bus.commandReg = 8'h80;
    #1;
    chk("rst dack hi", {4'd0, bus.DACK}, 8'h00);
    bus.commandReg = 8'h00;
    tick;
    rst = 1'b0;
    tick;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Controller disabled: no hold request
    bus.commandReg = 8'h04; bus.DREQ = 4'b0001;
    tick; tick;
    chk("disable hrq", {7'd0, bus.HRQ}, 8'd0);

    // Request withdrawn before HLDA
    bus.commandReg = 8'h00; bus.DREQ = 4'b0100;
    tick;
    chk("wd hrq up", {7'd0, bus.HRQ}, 8'd1);
    bus.DREQ = 4'b0000;
    tick;
    chk("wd hrq down", {7'd0, bus.HRQ}, 8'd0);
    tick;
    chk("wd idle", {7'd0, bus.HRQ}, 8'd0);

    // HLDA drops in GRANT without service: no clear, no rotation (ptr 0)
    to_grant(8'h10, 4'b0000, 4'b0010);
    chk("ab grant", {4'd0, bus.VALID_DREQ}, 8'h02);
    bus.HLDA = 1'b0;
    tick;
    chk("ab hrq",   {7'd0, bus.HRQ}, 8'd0);
    chk("ab valid", {4'd0, bus.VALID_DREQ}, 8'd0);
    chk("ab swclr", {4'd0, bus.swReqClr}, 8'd0);
    bus.requestReg = 4'h0;
    tick;
    chk("ab swclr2", {4'd0, bus.swReqClr}, 8'd0);
    bus.DREQ = 4'b1111;
    tick;
    chk("ab norot", {6'd0, bus.activeCh}, 8'd0);
    bus.DREQ = 4'b0000;
    tick; tick;

    // Disable during GRANT keeps the grant; simultaneous done + HLDA fall
    to_grant(8'h00, 4'b0000, 4'b1000);
    bus.commandReg = 8'h04;
    tick;
    chk("dis grant", {4'd0, bus.VALID_DREQ}, 8'h08);
    bus.HLDA = 1'b0; bus.serviceDone = 1'b1;
    tick;
    bus.serviceDone = 1'b0; bus.requestReg = 4'h0;
    chk("sim swclr", {4'd0, bus.swReqClr}, 8'h08);
    chk("sim hrq",   {7'd0, bus.HRQ}, 8'd0);
    tick;
    chk("sim idle", {4'd0, bus.swReqClr}, 8'd0);

    // Asynchronous reset in the middle of GRANT
    to_grant(8'h80, 4'b0001, 4'b0000);
    chk("ar dack on", {4'd0, bus.DACK}, 8'h01);
    #3 rst = 1'b1;
    #1;
    chk("ar hrq",   {7'd0, bus.HRQ}, 8'd0);
    chk("ar dack",  {4'd0, bus.DACK}, 8'h00);
    chk("ar valid", {4'd0, bus.VALID_DREQ}, 8'd0);
    chk("ar swclr", {4'd0, bus.swReqClr}, 8'd0);
    bus.DREQ = 4'h0; bus.HLDA = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("ar after", {7'd0, bus.HRQ}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
